// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial datapath primitives.
// Contents:
//   serial_state_e - control states of the bit-serial operators (IDLE, RUN, DONE).
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
// Ports:
//   a, b  - operand bits (minuend, subtrahend)
//   bin   - borrow in
//   d     - difference bit
//   bout  - borrow out
// Three implementation styles, picked at compile time like the sibling adder primitives:
// FULL_SUBTRACTOR_UDP (truth tables), FULL_SUBTRACTOR_GATES (gate primitives), else assign.

`ifdef FULL_SUBTRACTOR_UDP
primitive fs_d_udp (output d, input a, input b, input bin);
    table
    //  a b bin : d
        0 0 0   : 0;
        0 0 1   : 1;
        0 1 0   : 1;
        0 1 1   : 0;
        1 0 0   : 1;
        1 0 1   : 0;
        1 1 0   : 0;
        1 1 1   : 1;
    endtable
endprimitive

primitive fs_bout_udp (output bout, input a, input b, input bin);
    table
    //  a b bin : bout
        0 0 0   : 0;
        0 0 1   : 1;
        0 1 0   : 1;
        0 1 1   : 1;
        1 0 0   : 0;
        1 0 1   : 0;
        1 1 0   : 0;
        1 1 1   : 1;
    endtable
endprimitive
`endif

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

`ifdef FULL_SUBTRACTOR_UDP
    // UDP instances only accept ordered connections.
    fs_d_udp    u_d    (d, a, b, bin);
    fs_bout_udp u_bout (bout, a, b, bin);
`elsif FULL_SUBTRACTOR_GATES
    logic axb, na, nx, t0, t1;
    xor g_axb  (axb, a, b);
    xor g_d    (d, axb, bin);
    not g_na   (na, a);
    and g_t0   (t0, na, b);
    not g_nx   (nx, axb);
    and g_t1   (t1, nx, bin);
    or  g_bout (bout, t0, t1);
`else
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
`endif

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB-first, one bit per clock, through a
// single full_subtractor cell. Latency WIDTH cycles from acceptance.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - operand handshake; a (minuend), b (subtrahend)
//   out_valid/out_ready - result handshake
//   diff                - (a - b) mod 2^WIDTH
//   borrow              - unsigned borrow-out (a < b)
//   ovf                 - two's-complement overflow
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int unsigned   CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    serial_state_e state_q, state_d;

    logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
    logic [CW-1:0]    cnt;
    logic             br, a_msb, b_msb, ovf_q;
    logic             d_bit, bo_bit;
    logic             accept, last;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (bo_bit)
    );

    // Held low during reset so no operand is offered an accept while the block is cleared.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CntLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        br    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= {d_bit, diff_sh[WIDTH-1:1]};
                    br      <= bo_bit;
                    if (last) begin
                        // d_bit is the result MSB on the final bit cycle.
                        ovf_q <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff   = diff_sh;
    assign borrow = br;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;

    int n_assert = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] d;
        logic       bo, ov;
        int         sd;
        d  = x - y;
        bo = (x < y);
        sd = int'($signed(x)) - int'($signed(y));
        ov = (sd > 127) || (sd < -128);
        return {d, bo, ov};
    endfunction

    task automatic wait_out(input string tag, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, 64'(cyc), 64'd8);
    endtask

    task automatic check_result(input string tag, input logic [7:0] x, input logic [7:0] y);
        logic [9:0] e;
        e = model(x, y);
        check({tag, ".diff"},   64'(diff),   64'(e[9:2]));
        check({tag, ".borrow"}, 64'(borrow), 64'(e[1]));
        check({tag, ".ovf"},    64'(ovf),    64'(e[0]));
    endtask

    // Called at a sample point with the block idle.
    task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y);
        int cyc;
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".in_ready_run"}, 64'(in_ready), 64'd0);
        wait_out(tag, cyc);
        check_result(tag, x, y);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, ".in_ready_back"},  64'(in_ready),  64'd1);
    endtask

    initial begin
        logic [7:0]  rx, ry;
        logic [9:0]  exp_q[$];
        int          acc_t[$];
        logic [9:0]  e;
        int          cyc, beats;
        logic [7:0]  held;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready",  64'(in_ready),  64'd0);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.diff",      64'(diff),      64'd0);
        check("reset.borrow",    64'(borrow),    64'd0);
        check("reset.ovf",       64'(ovf),       64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("release.in_ready", 64'(in_ready), 64'd1);

        run_op("v5a_23", 8'h5A, 8'h23);
        run_op("v10_20", 8'h10, 8'h20);
        run_op("v80_01", 8'h80, 8'h01);
        run_op("v7f_ff", 8'h7F, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            run_op($sformatf("rand%0d", i), rx, ry);
        end

        // Backpressure: new operands offered while result is held.
        a = 8'h3C; b = 8'hC5; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 8'h99; b = 8'h42;
        wait_out("bp.first", cyc);
        check_result("bp.first", 8'h3C, 8'hC5);
        held = diff;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.hold.out_valid", 64'(out_valid), 64'd1);
            check("bp.hold.in_ready",  64'(in_ready),  64'd0);
            check("bp.hold.diff",      64'(diff),      64'(held));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.idle.in_ready",  64'(in_ready),  64'd1);
        check("bp.idle.out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.accepted.in_ready", 64'(in_ready), 64'd0);
        wait_out("bp.second", cyc);
        check_result("bp.second", 8'h99, 8'h42);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the third RUN cycle.
        a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst.in_ready",  64'(in_ready),  64'd0);
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.diff",      64'(diff),      64'd0);
        check("midrst.borrow",    64'(borrow),    64'd0);
        check("midrst.ovf",       64'(ovf),       64'd0);
        @(posedge clk); #1;
        check("midrst.held.out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("midrst.release.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        beats = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) beats++;
        end
        out_ready = 1'b0;
        check("midrst.no_beat", 64'(beats), 64'd0);
        run_op("vff_ff", 8'hFF, 8'hFF);

        // Back-to-back with both handshakes held high.
        a = 8'($urandom); b = 8'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 52; c++) begin
            logic took;
            took = 1'b0;
            if (out_valid) begin
                check("b2b.queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b.diff",   64'(diff),   64'(e[9:2]));
                    check("b2b.borrow", 64'(borrow), 64'(e[1]));
                    check("b2b.ovf",    64'(ovf),    64'(e[0]));
                end
            end
            if (in_ready) begin
                exp_q.push_back(model(a, b));
                acc_t.push_back(c);
                took = 1'b1;
            end
            @(posedge clk); #1;
            if (took) begin
                a = 8'($urandom); b = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        check("b2b.accept_count", 64'(acc_t.size()), 64'd6);
        for (int i = 1; i < acc_t.size(); i++) begin
            check("b2b.period", 64'(acc_t[i] - acc_t[i-1]), 64'd10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
